// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP multiplier exception stage.
//  round_values : runtime rounding mode codes
//  fp_class_t   : operand class after flush-to-zero decode
//  FL_*         : bit positions inside the 7-bit status flag vector
//  *_val        : bit patterns of special values (sign bit clear), returned
//                 in 64 bits so callers can slice to any width up to 64
package fp_mult_pkg;

  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } round_values;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_INF  = 2'd1,
    CLS_NAN  = 2'd2,
    CLS_NORM = 2'd3
  } fp_class_t;

  // flags = {invalid, inexact, huge, tiny, nan, inf, zero}
  localparam int FL_ZERO = 0;
  localparam int FL_INF  = 1;
  localparam int FL_NAN  = 2;
  localparam int FL_TINY = 3;
  localparam int FL_HUGE = 4;
  localparam int FL_INX  = 5;
  localparam int FL_INV  = 6;
  localparam int FL_W    = 7;

  function automatic logic [63:0] inf_val(int ew, int mw);
    return ((64'd1 << ew) - 64'd1) << mw;
  endfunction

  function automatic logic [63:0] max_norm(int ew, int mw);
    return (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1);
  endfunction

  function automatic logic [63:0] min_norm(int ew, int mw);
    return 64'd1 << mw;
  endfunction

  function automatic logic [63:0] qnan(int ew, int mw);
    return inf_val(ew, mw) | (64'd1 << (mw - 1));
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational class decode of one FP value (sign not needed).
//  exp_i  : biased exponent
//  frac_i : fraction
//  cls_o  : ZERO (zero or denormal, flushed), INF, NAN or NORM
module fp_classify
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W-1:0] frac_i,
  output fp_class_t        cls_o
);

  always_comb begin
    if (exp_i == '0)       cls_o = CLS_ZERO;
    else if (&exp_i)       cls_o = (frac_i == '0) ? CLS_INF : CLS_NAN;
    else                   cls_o = CLS_NORM;
  end

endmodule

// File: rtl/fp_exception_pipe.sv
// Two-stage exception / post-processing stage of the FP multiplier.
// S1 registers operand classes, result sign, datapath status and rounding
// mode; S2 registers the corrected result and its flags.
//  clk, rst                : clock, async active-high reset
//  in_valid/in_ready       : input handshake (a, b, z_calc, status, rnd_mode)
//  out_valid/out_ready     : output handshake (z, flags)
//  z, flags                : corrected result and {inv,inx,huge,tiny,nan,inf,zero}
//  sticky_flags, flags_clr : accumulated flags of accepted outputs, clear
module fp_exception_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter logic [MAN_W-1:0] QNAN_FRAC = {1'b1, {(MAN_W-1){1'b0}}},
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    z_calc,
  input  logic            overflow,
  input  logic            underflow,
  input  logic            inexact,
  input  logic [2:0]      rnd_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    z,
  output logic [FL_W-1:0] flags,
  output logic [FL_W-1:0] sticky_flags,
  input  logic            flags_clr
);

  localparam logic [W-1:0] INF_C  = W'(inf_val(EXP_W, MAN_W));
  localparam logic [W-1:0] MAXN_C = W'(max_norm(EXP_W, MAN_W));
  localparam logic [W-1:0] MINN_C = W'(min_norm(EXP_W, MAN_W));
  localparam logic [W-1:0] QNAN_C = {1'b0, {EXP_W{1'b1}}, QNAN_FRAC};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1 ----------------
  fp_class_t   cls_a_d, cls_b_d, cls_z_d;
  fp_class_t   cls_a_q, cls_b_q, cls_z_q;
  logic        s1_vld_q, sign_q, ovf_q, unf_q, inx_q;
  logic [W-1:0] zc_q;
  round_values rm_d, rm_q;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .exp_i(a[W-2:MAN_W]), .frac_i(a[MAN_W-1:0]), .cls_o(cls_a_d));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .exp_i(b[W-2:MAN_W]), .frac_i(b[MAN_W-1:0]), .cls_o(cls_b_d));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_z (
    .exp_i(z_calc[W-2:MAN_W]), .frac_i(z_calc[MAN_W-1:0]), .cls_o(cls_z_d));

  // Unused codes 6/7 collapse to round-to-nearest at capture time.
  assign rm_d = (rnd_mode > 3'd5) ? IEEE_near : round_values'(rnd_mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      cls_a_q  <= CLS_ZERO;
      cls_b_q  <= CLS_ZERO;
      cls_z_q  <= CLS_ZERO;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      rm_q     <= IEEE_near;
      zc_q     <= '0;
    end else if (adv) begin
      s1_vld_q <= in_valid;
      cls_a_q  <= cls_a_d;
      cls_b_q  <= cls_b_d;
      cls_z_q  <= cls_z_d;
      sign_q   <= a[W-1] ^ b[W-1];
      ovf_q    <= overflow;
      unf_q    <= underflow;
      inx_q    <= inexact;
      rm_q     <= rm_d;
      zc_q     <= z_calc;
    end
  end

  // ---------------- S2 ----------------
  logic [W-1:0]    z_d;
  logic [FL_W-1:0] fl_d;
  logic            to_inf, to_minn, rnd_inx;

  // Directed modes pick the larger magnitude only when rounding away from zero.
  assign to_inf  = (rm_q == IEEE_near) || (rm_q == near_up) || (rm_q == away_zero) ||
                   (rm_q == IEEE_pinf && !sign_q) || (rm_q == IEEE_ninf && sign_q);
  assign to_minn = (rm_q == away_zero) ||
                   (rm_q == IEEE_pinf && !sign_q) || (rm_q == IEEE_ninf && sign_q);

  always_comb begin
    z_d     = zc_q;
    fl_d    = '0;
    rnd_inx = 1'b0;
    if (cls_a_q == CLS_NAN || cls_b_q == CLS_NAN) begin
      z_d          = QNAN_C;
      fl_d[FL_NAN] = 1'b1;
    end else if ((cls_a_q == CLS_ZERO && cls_b_q == CLS_INF) ||
                 (cls_a_q == CLS_INF  && cls_b_q == CLS_ZERO)) begin
      z_d          = QNAN_C;
      fl_d[FL_NAN] = 1'b1;
      fl_d[FL_INV] = 1'b1;
    end else if (cls_a_q == CLS_INF || cls_b_q == CLS_INF) begin
      z_d          = {sign_q, INF_C[W-2:0]};
      fl_d[FL_INF] = 1'b1;
    end else if (cls_a_q == CLS_ZERO || cls_b_q == CLS_ZERO) begin
      z_d           = {sign_q, {(W-1){1'b0}}};
      fl_d[FL_ZERO] = 1'b1;
    end else if (ovf_q) begin
      fl_d[FL_HUGE] = 1'b1;
      rnd_inx       = 1'b1;
      if (to_inf) begin
        z_d          = {sign_q, INF_C[W-2:0]};
        fl_d[FL_INF] = 1'b1;
      end else begin
        z_d = {sign_q, MAXN_C[W-2:0]};
      end
    end else if (unf_q || cls_z_q == CLS_ZERO) begin
      if (!unf_q && zc_q[MAN_W-1:0] == '0) begin
        // exact zero product: nothing was lost, no rounding applies
        z_d           = {sign_q, {(W-1){1'b0}}};
        fl_d[FL_ZERO] = 1'b1;
      end else begin
        fl_d[FL_TINY] = 1'b1;
        rnd_inx       = 1'b1;
        if (to_minn) begin
          z_d = {sign_q, MINN_C[W-2:0]};
        end else begin
          z_d           = {sign_q, {(W-1){1'b0}}};
          fl_d[FL_ZERO] = 1'b1;
        end
      end
    end else if (cls_z_q == CLS_INF || cls_z_q == CLS_NAN) begin
      z_d           = {sign_q, INF_C[W-2:0]};
      fl_d[FL_INF]  = 1'b1;
      fl_d[FL_HUGE] = 1'b1;
    end
    fl_d[FL_INX] = inx_q || rnd_inx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= s1_vld_q;
      z         <= z_d;
      flags     <= fl_d;
    end
  end

  // Clear wins over a same-cycle accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         sticky_flags <= '0;
    else if (flags_clr)              sticky_flags <= '0;
    else if (out_valid && out_ready) sticky_flags <= sticky_flags | flags;
  end

endmodule

// File: tb/tb_fp_exception_pipe.sv
// Scoreboard bench for fp_exception_pipe (binary32 defaults).
module tb_fp_exception_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b, z_calc;
  logic        overflow, underflow, inexact;
  logic [2:0]  rnd_mode;
  logic        out_valid, out_ready;
  logic [31:0] z;
  logic [6:0]  flags, sticky_flags;
  logic        flags_clr;

  fp_exception_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .z_calc(z_calc), .overflow(overflow), .underflow(underflow),
    .inexact(inexact), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .flags(flags), .sticky_flags(sticky_flags),
    .flags_clr(flags_clr));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] z; logic [6:0] f; } exp_t;
  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [6:0] exp_sticky = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endfunction

  function automatic void fail(string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout", nm);
  endfunction

  // monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_output");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("z", z, e.z);
        chk("flags", {25'd0, flags}, {25'd0, e.f});
        exp_sticky = exp_sticky | e.f;
      end
    end
  end

  // called just after a posedge; returns just after the transfer edge
  task automatic send(input logic [31:0] ia, ib, iz, input logic io, iu, ix,
                      input logic [2:0] im, input logic [31:0] ez, input logic [6:0] ef);
    int   n;
    logic hs;
    exp_t e;
    a = ia; b = ib; z_calc = iz; overflow = io; underflow = iu; inexact = ix;
    rnd_mode = im; in_valid = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); n++;
    end
    if (!hs) fail("send_handshake");
    else begin e.z = ez; e.f = ef; exp_q.push_back(e); end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) fail("drain");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    a = '0; b = '0; z_calc = '0; overflow = 0; underflow = 0; inexact = 0; rnd_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_z", z, 32'd0);
    chk("rst_flags", {25'd0, flags}, 32'd0);
    chk("rst_sticky", {25'd0, sticky_flags}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic normal product, 2-cycle latency
    send(32'h3F800000, 32'h40000000, 32'h40000000, 0, 0, 0, 3'd0, 32'h40000000, 7'h00);
    @(negedge clk);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // overflow / special operands / underflow / misc
    send(32'h7F000000, 32'hC0000000, 32'h00000000, 1, 0, 0, 3'd0, 32'hFF800000, 7'h32);
    send(32'h7F000000, 32'hC0000000, 32'h00000000, 1, 0, 0, 3'd2, 32'hFF7FFFFF, 7'h30);
    send(32'h7F000000, 32'h40000000, 32'h00000000, 1, 0, 0, 3'd7, 32'h7F800000, 7'h32);
    send(32'h7F000000, 32'h40000000, 32'h00000000, 1, 0, 0, 3'd1, 32'h7F7FFFFF, 7'h30);
    send(32'h00000000, 32'h7F800000, 32'h00000000, 0, 0, 0, 3'd0, 32'h7FC00000, 7'h44);
    send(32'h00000001, 32'h7F800000, 32'h00000000, 0, 0, 0, 3'd0, 32'h7FC00000, 7'h44);
    send(32'h7FC00001, 32'h3F800000, 32'h00000000, 0, 0, 0, 3'd0, 32'h7FC00000, 7'h04);
    send(32'hFF800000, 32'h40000000, 32'h00000000, 0, 0, 0, 3'd0, 32'hFF800000, 7'h02);
    send(32'h80000000, 32'h40000000, 32'h00000000, 0, 0, 0, 3'd0, 32'h80000000, 7'h01);
    send(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 3'd5, 32'h00800000, 7'h28);
    send(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 3'd3, 32'h00000000, 7'h29);
    send(32'h3F800000, 32'h3F800000, 32'h7F800000, 0, 0, 0, 3'd0, 32'h7F800000, 7'h12);
    send(32'h3F800000, 32'h3F800000, 32'h3F800001, 0, 0, 1, 3'd0, 32'h3F800001, 7'h20);
    send(32'h3F800000, 32'h3F800000, 32'h00000000, 0, 0, 0, 3'd0, 32'h00000000, 7'h01);
    send(32'h3F800000, 32'h3F800000, 32'h00000005, 0, 0, 0, 3'd0, 32'h00000000, 7'h29);
    drain();

    // backpressure: 3 offered, consumer stalled
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000, 32'h40000000, 32'h40000000, 0, 0, 0, 3'd0, 32'h40000000, 7'h00);
        send(32'hFF800000, 32'h40000000, 32'h00000000, 0, 0, 0, 3'd0, 32'hFF800000, 7'h02);
        send(32'h80000000, 32'h40000000, 32'h00000000, 0, 0, 0, 3'd0, 32'h80000000, 7'h01);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_z", z, 32'h40000000);
        repeat (2) begin
          @(negedge clk);
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          chk("stall_z_hold", z, 32'h40000000);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // sticky accumulation and clear priority
    chk("sticky_acc", {25'd0, sticky_flags}, {25'd0, exp_sticky});
    flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    exp_sticky = '0;
    chk("sticky_clr", {25'd0, sticky_flags}, 32'd0);
    send(32'h00000000, 32'h7F800000, 32'h00000000, 0, 0, 0, 3'd0, 32'h7FC00000, 7'h44);
    @(posedge clk); #1;
    chk("clr_cycle_valid", {31'd0, out_valid}, 32'd1);
    flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    exp_sticky = '0;
    chk("sticky_clr_prio", {25'd0, sticky_flags}, 32'd0);
    send(32'h7FC00001, 32'h3F800000, 32'h00000000, 0, 0, 0, 3'd0, 32'h7FC00000, 7'h04);
    drain();
    chk("sticky_after", {25'd0, sticky_flags}, 32'h04);

    // reset mid-stream flushes the in-flight result
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 32'h40000000, 0, 0, 0, 3'd0, 32'h40000000, 7'h00);
    @(posedge clk); #1;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_z", z, 32'd0);
    chk("rst_async_sticky", {25'd0, sticky_flags}, 32'd0);
    exp_q.delete();
    exp_sticky = '0;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h7F000000, 32'hC0000000, 32'h00000000, 1, 0, 0, 3'd2, 32'hFF7FFFFF, 7'h30);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
